// File: rtl/conv_result_streamer.sv
// Snapshots one output channel of the Conv2d result bus and streams it out one
// word per valid/ready handshake. Optional output ReLU: define CONV_STREAM_RELU_EN.
module conv_result_streamer #(
    parameter int N = 24,
    parameter int Q = 13,
    parameter int h = 4,
    parameter int w = 41,
    parameter int p = 1,
    parameter int OH = h - 2 + 2 * p,
    parameter int OW = w - 2 + 2 * p,
    parameter int NW = OH * OW,
    parameter int RW = (OH > 1) ? $clog2(OH) : 1,
    parameter int CW = (OW > 1) ? $clog2(OW) : 1
) (
    input  logic              clk,
    input  logic              global_rst,
    input  logic              start,
    input  logic [N*NW-1:0]   result_in,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last
);

    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OW - 1);
    // Fixed-point 0.0 in the QN.Q format; also the ReLU clamp value.
    localparam logic [N-1:0] FX_ZERO = N'(0) << Q;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_FIN    = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [KW-1:0]       r_k;
    logic [KW-1:0]       w_k_next;
    logic [RW-1:0]       r_row;
    logic [RW-1:0]       w_row_next;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       w_col_next;
    logic                w_load;
    logic                w_capture;
    logic [N-1:0]        w_word;
    logic [N*NW-1:0]     r_snap;
    logic [N-1:0]        r_data;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;
    logic                r_last;

    function automatic logic [N-1:0] f_out_word(input logic [N-1:0] word);
`ifdef CONV_STREAM_RELU_EN
        if (word[N-1]) begin
            f_out_word = FX_ZERO;
        end else begin
            f_out_word = word;
        end
`else
        f_out_word = word;
`endif
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, next word index and row/column tracking.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_row_next   = r_row;
        w_col_next   = r_col;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_STREAM;
                    w_k_next     = '0;
                    w_row_next   = '0;
                    w_col_next   = '0;
                    w_load       = 1'b1;
                    w_capture    = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (r_k == K_LAST) begin
                        w_state_next = ST_FIN;
                    end else begin
                        w_load   = 1'b1;
                        w_k_next = r_k + 1'b1;
                        if (r_col == C_LAST) begin
                            w_col_next = '0;
                            w_row_next = r_row + 1'b1;
                        end else begin
                            w_col_next = r_col + 1'b1;
                        end
                    end
                end else begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_FIN: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Word 0 comes straight off the bus on the capture cycle; later words from the snapshot.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_word = result_in[N-1:0];
        end else begin
            w_word = r_snap[N*int'(w_k_next) +: N];
        end
    end

    // Registered outputs, word index and snapshot.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            r_k     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_data  <= FX_ZERO;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= 1'b0;
            r_snap  <= '0;
        end else begin
            r_k     <= w_k_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
            r_valid <= (w_state_next == ST_STREAM);
            r_busy  <= (w_state_next == ST_STREAM);
            r_done  <= (w_state_next == ST_FIN);
            r_last  <= (w_state_next == ST_STREAM) && (w_k_next == K_LAST);
            if (w_load) begin
                r_data <= f_out_word(w_word);
            end else begin
                r_data <= r_data;
            end
            if (w_capture) begin
                r_snap <= result_in;
            end else begin
                r_snap <= r_snap;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = r_last;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Directed self-checking bench for conv_result_streamer (default 4x41 result map).
module tb_conv_result_streamer;

    localparam int N  = 24;
    localparam int OW = 41;
    localparam int NW = 164;

    logic              clk = 1'b0;
    logic              global_rst;
    logic              start;
    logic [N*NW-1:0]   result_in;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;
    logic [1:0]        out_row;
    logic [5:0]        out_col;
    logic              out_last;

    logic [N*NW-1:0]   pat;
    int                n_tests = 0;
    int                n_fail  = 0;

    conv_result_streamer dut (
        .clk        (clk),
        .global_rst (global_rst),
        .start      (start),
        .result_in  (result_in),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] model_word(input logic [N-1:0] wd);
`ifdef CONV_STREAM_RELU_EN
        model_word = wd[N-1] ? 24'h000000 : wd;
`else
        model_word = wd;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        check({tag, "_done"},  32'(done),      32'(exp_done));
    endtask

    task automatic do_start();
        result_in = pat;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams with out_ready=1 from word 0; optionally pulses start at pulse_at or stops at stop_at.
    task automatic stream_all(input string tag, input int pulse_at, input int stop_at);
        for (int k = 0; k < NW; k++) begin
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_busy"},  32'(busy),      32'd1);
            check({tag, "_done"},  32'(done),      32'd0);
            check({tag, "_data"},  32'(out_data),  32'(model_word(pat[N*k +: N])));
            check({tag, "_row"},   32'(out_row),   32'(k / OW));
            check({tag, "_col"},   32'(out_col),   32'(k % OW));
            check({tag, "_last"},  32'(out_last),  32'(k == NW - 1));
            if (k == stop_at) return;
            start = (k == pulse_at);
            tick();
            start = 1'b0;
        end
        check_idle({tag, "_fin"}, 1'b1);
        tick();
        check_idle({tag, "_post"}, 1'b0);
    endtask

    initial begin
        int k;
        int cyc;
        global_rst = 1'b1;
        start      = 1'b1;
        out_ready  = 1'b0;
        result_in  = '0;
        pat        = '0;

        // 1: reset held 3 cycles with start asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("rst", 1'b0);
            check("rst_data", 32'(out_data), 32'd0);
            check("rst_row",  32'(out_row),  32'd0);
            check("rst_col",  32'(out_col),  32'd0);
        end
        global_rst = 1'b0;
        start      = 1'b0;
        tick();
        check_idle("rst_rel", 1'b0);

        // 2: full stream, word k = k, ready held high; start during FIN ignored
        out_ready = 1'b1;
        for (int i = 0; i < NW; i++) pat[N*i +: N] = 24'(i);
        do_start();
        check("s2_first", 32'(out_data), 32'h000000);
        for (int i = 0; i < NW; i++) begin
            check("s2_data", 32'(out_data), 32'(i));
            check("s2_row",  32'(out_row),  32'(i / 41));
            check("s2_col",  32'(out_col),  32'(i % 41));
            check("s2_last", 32'(out_last), 32'(i == 163));
            check("s2_done", 32'(done),     32'd0);
            tick();
        end
        check_idle("s2_fin", 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_idle("s2_fin_start", 1'b0);
        tick();
        check_idle("s2_fin_start2", 1'b0);

        // 3: backpressure, out_ready pattern 1,0,0,1,...
        for (int i = 0; i < NW; i++) pat[N*i +: N] = 24'(3 * i + 5);
        do_start();
        k = 0;
        cyc = 0;
        while (k < NW && cyc < 1000) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'(3 * k + 5));
            check("bp_row",   32'(out_row),   32'(k / OW));
            check("bp_col",   32'(out_col),   32'(k % OW));
            check("bp_last",  32'(out_last),  32'(k == NW - 1));
            check("bp_done",  32'(done),      32'd0);
            if (out_ready) k++;
            tick();
            cyc++;
        end
        check("bp_count", 32'(k), 32'(NW));
        check_idle("bp_fin", 1'b1);
        out_ready = 1'b1;
        tick();
        check_idle("bp_post", 1'b0);

        // 4: snapshot isolation and start ignored mid-stream
        for (int i = 0; i < NW; i++) pat[N*i +: N] = 24'h5A0000 | 24'(i);
        do_start();
        result_in = '1;
        stream_all("snap", 10, -1);

        // 5: reset at k=50, then fresh stream from k=0
        for (int i = 0; i < NW; i++) pat[N*i +: N] = 24'h010000 + 24'(i);
        do_start();
        stream_all("mid", -1, 50);
        global_rst = 1'b1;
        tick();
        global_rst = 1'b0;
        check_idle("mrst", 1'b0);
        check("mrst_data", 32'(out_data), 32'd0);
        check("mrst_row",  32'(out_row),  32'd0);
        check("mrst_col",  32'(out_col),  32'd0);
        tick();
        check_idle("mrst2", 1'b0);
        do_start();
        stream_all("fresh", -1, -1);

        // 6: negative / positive fixed-point words
        pat = '0;
        pat[N*0 +: N] = 24'hFFE000;
        pat[N*1 +: N] = 24'h002000;
        do_start();
`ifdef CONV_STREAM_RELU_EN
        check("relu_w0", 32'(out_data), 32'h000000);
`else
        check("relu_w0", 32'(out_data), 32'hFFE000);
`endif
        stream_all("relu", -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
